// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin arbiter and sequencer for the single-port shared L2 array.
// One read or write strobe is forwarded at a time; completion is signalled by a one-cycle ack.
module l2_port_arbiter #(
  parameter int NCORES  = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req_i,
  input  logic [NCORES-1:0]        req_we_i,
  input  logic [NCORES*ADDR_W-1:0] req_addr_i,
  input  logic [NCORES*DATA_W-1:0] req_wdata_i,
  output logic [NCORES-1:0]        ack_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic [$clog2(NCORES)-1:0] grant_id_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);
  localparam int IW = $clog2(NCORES);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NCORES-1:0] ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, busy_q, busy_d, rd_q, rd_d, wr_q, wr_d, go, done;
  // scan from the far end so the requester closest to ptr overwrites the others
  always_comb begin
    win = ptr_q;
    idx = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NCORES);
      if (req_i[idx]) win = idx;
    end
  end
  assign go   = state_q == IDLE && |req_i;
  assign done = state_q == WAIT && cnt_q == '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = done ? ACK : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_d = go ? win : grant_q;
    we_d    = go ? req_we_i[win] : we_q;
    addr_d  = go ? req_addr_i[win*ADDR_W +: ADDR_W] : addr_q;
    wdata_d = go ? req_wdata_i[win*DATA_W +: DATA_W] : wdata_q;
    rd_d    = go && !req_we_i[win];
    wr_d    = go && req_we_i[win];
    cnt_d   = state_q == ISSUE ? CW'(MEM_LAT - 1) : (state_q == WAIT && !done) ? cnt_q - 1'b1 : cnt_q;
    rdata_d = done && !we_q ? mem_rdata_i : rdata_q;
    ack_d   = done ? NCORES'(1) << grant_q : '0;
    ptr_d   = state_q != ACK ? ptr_q : grant_q == IW'(NCORES - 1) ? '0 : grant_q + 1'b1;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;
  assign mem_read_o  = rd_q;
  assign mem_write_o = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
endmodule
